// File: rtl/adder_share_arb.sv
// Round-robin sequencer feeding one shared LAT-cycle adder; sums return LAT+2 cycles after grant, no response backpressure.
// Optional operand shadow self-check is built when ADDER_SHARE_CHECK_EN is defined (err stays 0 otherwise).
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_cin,
  input  logic [W:0]        add_sum,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W:0]        rsp_sum,
  output logic              err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_id;
  logic            xfer;
  logic [W-1:0]    add_a_q, add_b_q;
  logic            add_cin_q;
  logic [LAT:0]    tag_vld_q;
  logic [IW-1:0]   tag_id_q [LAT+1];
  logic [NREQ-1:0] rsp_valid_q;
  logic [W:0]      rsp_sum_q;

  // Scan from the highest offset down so the last hit is the first requester at or after ptr.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IW'(idx);
      end
    end
  end

  assign xfer      = gnt_vld && !resetn;
  assign req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      tag_vld_q   <= '0;
      for (int i = 0; i <= LAT; i++) tag_id_q[i] <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      add_a_q     <= xfer ? req_a[gnt_id*W +: W] : '0;
      add_b_q     <= xfer ? req_b[gnt_id*W +: W] : '0;
      add_cin_q   <= xfer ? req_cin[gnt_id] : 1'b0;
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= gnt_id;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      // Last tag stage lines up with the adder output for the same operation.
      if (tag_vld_q[LAT]) begin
        rsp_valid_q <= NREQ'(1) << tag_id_q[LAT];
        rsp_sum_q   <= add_sum;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;

`ifdef ADDER_SHARE_CHECK_EN
  logic [W-1:0] sh_a_q   [LAT+1];
  logic [W-1:0] sh_b_q   [LAT+1];
  logic         sh_cin_q [LAT+1];
  logic [W:0]   sh_sum;
  logic         err_q;

  assign sh_sum = {1'b0, sh_a_q[LAT]} + {1'b0, sh_b_q[LAT]} + {{W{1'b0}}, sh_cin_q[LAT]};

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i <= LAT; i++) begin
        sh_a_q[i]   <= '0;
        sh_b_q[i]   <= '0;
        sh_cin_q[i] <= 1'b0;
      end
      err_q <= 1'b0;
    end else begin
      sh_a_q[0]   <= xfer ? req_a[gnt_id*W +: W] : '0;
      sh_b_q[0]   <= xfer ? req_b[gnt_id*W +: W] : '0;
      sh_cin_q[0] <= xfer ? req_cin[gnt_id] : 1'b0;
      for (int i = 1; i <= LAT; i++) begin
        sh_a_q[i]   <= sh_a_q[i-1];
        sh_b_q[i]   <= sh_b_q[i-1];
        sh_cin_q[i] <= sh_cin_q[i-1];
      end
      if (tag_vld_q[LAT] && (add_sum != sh_sum)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that shares one pipelined W-bit carry-lookahead adder among NREQ requesters. Each requester offers operands over a valid/ready handshake. The block issues at most one operation per cycle into the adder and tracks the requester ID through a tag pipeline matched to the adder latency. It returns each sum to the originating requester with a one-cycle valid pulse. It sits between the requesting datapath units and the single shared adder instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width; sums are W+1 bits
- LAT, 2, adder latency in clock edges, from add_a/add_b/add_cin changing to the matching add_sum

Ports:
- clk  in  1  single clock; all logic is rising-edge
- resetn  in  1  synchronous reset, active-high: asserted when 1, sampled on the clk rising edge
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  one-hot grant; at most one bit is high
- req_a  in  NREQ*W  packed operand A; requester i uses bits [i*W +: W]
- req_b  in  NREQ*W  packed operand B, same packing as req_a
- req_cin  in  NREQ  per-requester carry-in
- add_a  out  W  registered operand A to the shared adder
- add_b  out  W  registered operand B to the shared adder
- add_cin  out  1  registered carry-in to the shared adder
- add_sum  in  W+1  adder result, valid LAT edges after its operands
- rsp_valid  out  NREQ  one-hot, single-cycle result strobe
- rsp_sum  out  W+1  result, broadcast to all requesters; qualified by rsp_valid
- err  out  1  sticky self-check error (see Configuration)

## Operation
- Round-robin pointer ptr, range 0..NREQ-1, is 0 after reset.
- Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, … with wrap modulo NREQ.
- req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0. If no req_valid bit is set, req_ready=0.
- A transfer happens at an edge where req_valid[g] and req_ready[g] are both 1. At that edge:
  - add_a, add_b, add_cin load requester g's operands.
  - ptr loads (g+1) mod NREQ.
  - A tag entry {valid=1, id=g} enters the tag pipeline.
- At an edge with no transfer:
  - add_a, add_b, add_cin load 0.
  - A tag entry with valid=0 enters the pipeline.
  - ptr holds.
- Tag pipeline depth is LAT+1 stages.
- When a valid tag exits the pipeline, that edge registers rsp_sum ← add_sum and rsp_valid ← one-hot(id). Otherwise rsp_valid ← 0 and rsp_sum holds its previous value.
- Responses return in issue order. Responses have no backpressure; a requester must accept rsp_valid in the cycle it is high.
- A requester may hold req_valid across multiple grants. Each grant is a separate operation.
- Arithmetic: the sum is a+b+cin, W+1 bits; maximum is 2^(W+1)-1. The block does not alter add_sum.

## Timing
- Reset values: req_ready=0 while resetn=1. After reset, add_a, add_b, add_cin, rsp_valid, rsp_sum and err are 0, ptr=0, and all tag stages are invalid.
- Throughput: one operation per cycle with NREQ requesters continuously valid; each requester gets one grant every NREQ cycles.
- Latency: for a transfer at edge E0, rsp_valid pulses for exactly the cycle after edge E0+LAT+1.
- Simultaneous events: an issue and a response for different operations in the same cycle are independent; a requester may have up to LAT+1 operations in flight.
- Reset mid-operation: all in-flight tags are discarded. No rsp_valid pulse occurs for any operation issued before reset.

## Configuration
- ADDER_SHARE_CHECK_EN
  - Defined: a shadow pipeline of LAT+1 stages carries the issued operands alongside the tags. When a valid tag exits, add_sum is compared with a+b+cin of the shadow operands. On a mismatch, err is set to 1 at that edge and stays 1 until reset.
  - Not defined: no shadow logic is built and err is constantly 0.

## Test plan
- Single requester 1 with a=100, b=27, cin=1 → req_ready[1] high in the same cycle; rsp_valid=4'b0010 with rsp_sum=128 for the cycle after edge E0+LAT+1.
- All four requesters valid from reset, holding valid → grants in order 0,1,2,3,0,…; rsp_valid sequence is 0001, 0010, 0100, 1000 on consecutive cycles with the correct sums.
- Requester 2 granted, then requesters 0 and 3 both valid → requester 3 is granted before requester 0 (ptr=3).
- a=255, b=255, cin=1 → rsp_sum=511; a=0, b=0, cin=0 → rsp_sum=0 with rsp_valid still pulsing.
- Three operations in flight, then resetn=1 for one cycle → no rsp_valid pulse for those operations; all outputs are 0; the next grant goes to the lowest-indexed valid requester.
- Macro defined, with an adder model that forces add_sum bit 0 low, and a=1, b=0, cin=0 → err=1 after the response edge and err stays 1 through later correct sums. Macro undefined, same stimulus → err stays 0.
